// File: rtl/stream_share_rr2_pkg.sv
// Shared definitions for the two-requester stream sharing block.
//   src_e    : source tag stored per in-flight item (A or B)
//   rr_pick  : round-robin choice between requesters A and B
package stream_share_rr2_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Picks the only valid requester. When both are valid, picks the one
    // that did not win last time. When neither is valid, returns A; the
    // caller qualifies the result with the requester's valid.
    function automatic src_e rr_pick(input logic a_valid, input logic b_valid,
                                     input src_e last_grant);
        src_e pick;
        pick = SRC_A;
        if (a_valid && b_valid) begin
            if (last_grant == SRC_A) pick = SRC_B;
            else                     pick = SRC_A;
        end else if (b_valid) begin
            pick = SRC_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_tag_fifo.sv
// One-bit-wide tag FIFO recording which requester owns each in-flight item.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_tag    write one tag (caller never pushes when full)
//   pop               drop the head tag (caller never pops when empty)
//   head              tag at the read pointer
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module stream_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Pointers carry one extra bit so full and empty differ when the
    // index bits are equal.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        mem_q [DEPTH];

    // NOTE: every combinational output is given a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: tag storage is not reset; an entry is only read after it has
    // been written, and the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_tag;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == FULL_COUNT);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/stream_share_rr2.sv
// Shares one in-order stream worker between two requester streams A and B.
// A round-robin arbiter feeds the worker; a tag FIFO remembers the source of
// every accepted item so each worker result is routed back to its owner.
// Both paths are pure combinational forwarding (zero added latency).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   a_in/_valid/_ready                requester A input stream
//   b_in/_valid/_ready                requester B input stream
//   w_in/_valid/_ready                stream into the worker
//   w_out/_valid/_ready               stream out of the worker
//   a_out/_valid/_ready               results returned to A
//   b_out/_valid/_ready               results returned to B
//   inflight                          items currently inside the worker
//   err_orphan                        sticky: worker output with no tag
module stream_share_rr2
    import stream_share_rr2_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             a_in,
    input  logic                         a_in_valid,
    output logic                         a_in_ready,
    input  logic [WIDTH-1:0]             b_in,
    input  logic                         b_in_valid,
    output logic                         b_in_ready,
    output logic [WIDTH-1:0]             w_in,
    output logic                         w_in_valid,
    input  logic                         w_in_ready,
    input  logic [WIDTH-1:0]             w_out,
    input  logic                         w_out_valid,
    output logic                         w_out_ready,
    output logic [WIDTH-1:0]             a_out,
    output logic                         a_out_valid,
    input  logic                         a_out_ready,
    output logic [WIDTH-1:0]             b_out,
    output logic                         b_out_valid,
    input  logic                         b_out_ready,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    output logic                         err_orphan
);

    src_e last_grant_q, last_grant_d;
    logic lock_q, lock_d;
    src_e locked_src_q, locked_src_d;
    logic err_orphan_q, err_orphan_d;

    logic fifo_full, fifo_empty, fifo_head;
    logic issue_fire, ret_fire;
    logic can_issue, ret_ok, grant_valid;
    src_e grant, head_src;

    stream_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue_fire),
        .push_tag (grant),
        .pop      (ret_fire),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (inflight)
    );

    assign head_src = src_e'(fifo_head);

    // Issue side. Gating on the registered full flag means a same-cycle pop
    // does not open a slot until the next cycle.
    always_comb begin
        can_issue = !fifo_full && !rst;
        // A stalled offer stays pinned to its requester until accepted.
        if (lock_q) grant = locked_src_q;
        else        grant = rr_pick(a_in_valid, b_in_valid, last_grant_q);
        grant_valid = (grant == SRC_A) ? a_in_valid : b_in_valid;

        w_in       = (grant == SRC_A) ? a_in : b_in;
        w_in_valid = can_issue && grant_valid;
        a_in_ready = can_issue && (grant == SRC_A) && w_in_ready;
        b_in_ready = can_issue && (grant == SRC_B) && w_in_ready;
        issue_fire = w_in_valid && w_in_ready;
    end

    // Return side: the head tag steers the single worker output.
    always_comb begin
        ret_ok      = !fifo_empty && !rst;
        a_out       = w_out;
        b_out       = w_out;
        a_out_valid = w_out_valid && ret_ok && (head_src == SRC_A);
        b_out_valid = w_out_valid && ret_ok && (head_src == SRC_B);
        w_out_ready = ret_ok && ((head_src == SRC_A) ? a_out_ready : b_out_ready);
        ret_fire    = w_out_valid && w_out_ready;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        locked_src_d = locked_src_q;
        err_orphan_d = err_orphan_q || (w_out_valid && fifo_empty);
        if (issue_fire) begin
            last_grant_d = grant;
            lock_d       = 1'b0;
        end else if (w_in_valid) begin
            lock_d       = 1'b1;
            locked_src_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_B;   // A wins the first tie after reset
            lock_q       <= 1'b0;
            locked_src_q <= SRC_A;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            locked_src_q <= locked_src_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign err_orphan = err_orphan_q;

endmodule
